// File: rtl/seq_monitor.sv
// seq_monitor: tracks a 3-bit counter against an expected sequence, counting full cycles and mismatches.
// Optional SEQ_MONITOR_STALL_EN: a repeat of the previously matched entry while locked is a stall, not an error.
module seq_monitor #(
    parameter int          LEN = 8,
    parameter logic [23:0] SEQ = 24'h97E4C8
) (
    input  logic       C,
    input  logic       nR,
    input  logic [2:0] Q,
    input  logic       EN,
    input  logic       CLR,
    output logic       LOCK,
    output logic       ERR,
    output logic       WRAP,
    output logic [2:0] IDX,
    output logic [7:0] CYC,
    output logic [7:0] ERRS
);
    if (LEN < 2 || LEN > 8) begin : g_bad_len
        $error("seq_monitor: LEN must be in 2..8");
    end

    typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_t;

    localparam logic [2:0] LAST = 3'(LEN - 1);

    function automatic logic [2:0] ent(input logic [2:0] i);
        return SEQ[3*i +: 3];
    endfunction

    state_t     state, state_nx;
    logic [2:0] idx_nx;
    logic       err_nx, wrap_nx, hit, stall;

    assign hit = Q == ent(IDX);
`ifdef SEQ_MONITOR_STALL_EN
    assign stall = Q == ent(IDX == 3'd0 ? LAST : IDX - 3'd1);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state <= SEARCH;
            IDX   <= '0;
            ERR   <= 1'b0;
            WRAP  <= 1'b0;
            CYC   <= '0;
            ERRS  <= '0;
        end else begin
            state <= state_nx;
            IDX   <= idx_nx;
            ERR   <= err_nx;
            WRAP  <= wrap_nx;
            CYC   <= CLR ? 8'd0 : (wrap_nx && CYC != 8'hFF) ? CYC + 8'd1 : CYC;
            ERRS  <= CLR ? 8'd0 : (err_nx && ERRS != 8'hFF) ? ERRS + 8'd1 : ERRS;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = IDX;
        err_nx   = 1'b0;
        wrap_nx  = 1'b0;
        if (EN) begin
            case (state)
                LOCKED: begin
                    if (hit) begin
                        idx_nx  = IDX == LAST ? 3'd0 : IDX + 3'd1;
                        wrap_nx = IDX == LAST;
                    end else if (!stall) begin
                        state_nx = FAULT;
                        idx_nx   = 3'd0;
                        err_nx   = 1'b1;
                    end
                end
                default: begin
                    if (Q == ent(3'd0)) begin
                        state_nx = LOCKED;
                        idx_nx   = 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        LOCK = state == LOCKED;
    end
endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter LEN, default 8: number of valid sequence entries, legal range 2..8.
REQ-002 Parameter SEQ, default 24'h97E4C8: packed expected sequence; entry i = SEQ[3i+2:3i]; default decodes to 0,1,3,2,6,7,5,4.
REQ-003 Port C  input  1: single clock; all state updates on the rising edge of C.
REQ-004 Port nR  input  1: reset; asynchronous, active-low.
REQ-005 Port Q  input  3: counter state bits from the JK counter chain, stable at rising C.
REQ-006 Port EN  input  1: sample enable; when 0, no state, index or count changes.
REQ-007 Port CLR  input  1: synchronous clear of CYC and ERRS.
REQ-008 Port LOCK  output  1: high while in state LOCKED.
REQ-009 Port ERR  output  1: one-cycle pulse on each detected mismatch.
REQ-010 Port WRAP  output  1: one-cycle pulse when a full sequence completes.
REQ-011 Port IDX  output  3: index of the next expected entry.
REQ-012 Port CYC  output  8: completed-sequence count, saturating.
REQ-013 Port ERRS  output  8: mismatch count, saturating.

Function
REQ-014 States SEARCH, LOCKED, FAULT; all transitions occur only on rising C with EN=1.
REQ-015 SEARCH: Q==SEQ entry 0 -> LOCKED with IDX=1; else stay SEARCH; no ERR in SEARCH.
REQ-016 LOCKED: Q==entry IDX -> IDX advances by one; IDX==LEN-1 on match -> IDX=0, WRAP pulses, CYC increments.
REQ-017 LOCKED: Q!=entry IDX (subject to REQ-026) -> FAULT, ERR pulses, ERRS increments, IDX=0.
REQ-018 FAULT: Q==entry 0 -> LOCKED with IDX=1, no ERR; else stay FAULT, no further ERR pulses.
REQ-019 ERR and WRAP are registered and high for exactly one C cycle after the triggering edge; both low when EN=0.
REQ-020 CYC and ERRS saturate at 8'hFF; no wrap to 0.
REQ-021 CLR=1 clears CYC and ERRS to 0 on that edge; CLR wins over a simultaneous increment; CLR does not affect state, IDX, LOCK, ERR or WRAP.
REQ-022 SEQ entries 0..LEN-1 are distinct; behaviour with duplicate entries is undefined.
REQ-023 LEN outside 2..8 is a parameter error; the block fails elaboration.

Reset
REQ-024 nR low asynchronously forces: state SEARCH, IDX=0, LOCK=0, ERR=0, WRAP=0, CYC=0, ERRS=0.
REQ-025 Reset asserted mid-sequence discards progress; after release, the first edge with EN=1 is evaluated per SEARCH.

Configuration
REQ-026 Macro SEQ_MONITOR_STALL_EN: defined -> in LOCKED, Q equal to the previously matched entry is a stall: no error, IDX unchanged, no WRAP; undefined -> such a repeat is a mismatch per REQ-017.

Verification
REQ-027 Defaults, EN=1, Q drives 5,0,1,3,2,6,7,5,4,0 -> LOCK high after the 0 sample; WRAP pulse after the 4; CYC=1; ERR never high.
REQ-028 Locked at IDX=3, Q=6 instead of 2 -> ERR single pulse, ERRS=1, LOCK=0; then Q=0 -> LOCK=1, IDX=1, no ERR.
REQ-029 Locked, Q=0,1,1 -> with SEQ_MONITOR_STALL_EN: IDX stays 2, ERR low; without it: ERR pulse, ERRS=1.
REQ-030 Force 300 mismatches (alternating Q=0 then Q=2) -> ERRS=8'hFF; CLR=1 on the same edge as the next mismatch -> ERRS=0.
REQ-031 LEN=4, Q=0,1,3,2,0 -> WRAP after the 2, IDX=0; nR pulsed low between clock edges mid-sequence -> all outputs 0 immediately, SEARCH.
REQ-032 EN=0 with arbitrary Q for 10 cycles while locked at IDX=5 -> IDX, LOCK, CYC, ERRS unchanged, ERR and WRAP low.
